mem_arbiter: RTL and testbench

- Sits directly downstream of the cache controller, between the I-cache and D-cache miss paths and the single unified multi-cycle main memory.
- Serves one line transaction at a time:
  - I-line fill;
  - D-line fill;
  - D-line fill preceded by a dirty-line write-back.
- Uses fixed D-over-I priority and a latency counter, and returns the filled line with a one-cycle done pulse.
- The pipeline is stalled (instr_rdy/data_rdy low) while any request is outstanding.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter_lat_timer.sv | 29 ++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encodings and width defaults for mem_arbiter
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W  = 14;
  localparam int DEF_LINE_W  = 64;
  localparam int DEF_MEM_LAT = 4;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_WB    = 3'd1,
    ARB_DRD   = 3'd2,
    ARB_IRD   = 3'd3,
    ARB_DRESP = 3'd4,
    ARB_IRESP = 3'd5
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache miss ports and main-memory port bundle for mem_arbiter
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_line;
  logic              i_done;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_evict;
  logic [ADDR_W-1:0] d_evict_addr;
  logic [LINE_W-1:0] d_wr_line;
  logic [LINE_W-1:0] d_line;
  logic              d_done;

  logic [ADDR_W-1:0] m_addr;
  logic              m_re;
  logic              m_we;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;

  // master is the arbiter side; slave is the caches plus memory
  modport master (
    input  i_req, i_addr, d_req, d_addr, d_evict, d_evict_addr, d_wr_line, m_rdata,
    output i_line, i_done, d_line, d_done, m_addr, m_re, m_we, m_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_addr, d_evict, d_evict_addr, d_wr_line, m_rdata,
    input  i_line, i_done, d_line, d_done, m_addr, m_re, m_we, m_wdata
  );

endinterface

// File: rtl/mem_arbiter_lat_timer.sv
// rtl/mem_arbiter_lat_timer.sv - arb_lat_timer: loadable down-counter with zero flag
module arb_lat_timer #(
  parameter int MEM_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - D-over-I line-fill arbiter for one multi-cycle memory; MEM_ARB_PERF_EN adds fill/write-back counters
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]   perf_ifill,
  output logic [15:0]   perf_dfill,
  output logic [15:0]   perf_wb
`endif
);

  arb_state_t        state, state_n;
  logic [ADDR_W-1:0] m_addr_n;
  logic [LINE_W-1:0] m_wdata_n;
  logic [LINE_W-1:0] i_line_n;
  logic [LINE_W-1:0] d_line_n;
  logic              m_re_n, m_we_n, i_done_n, d_done_n;
  logic              t_load, t_dec, t_zero;

  arb_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (t_load),
    .dec  (t_dec),
    .zero (t_zero)
  );

  // Every output is a register; the comb block only computes its next value.
  always_comb begin
    state_n   = state;
    m_addr_n  = bus.m_addr;
    m_wdata_n = bus.m_wdata;
    i_line_n  = bus.i_line;
    d_line_n  = bus.d_line;
    m_re_n    = 1'b0;
    m_we_n    = 1'b0;
    i_done_n  = 1'b0;
    d_done_n  = 1'b0;
    t_load    = 1'b0;
    t_dec     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (bus.d_req && bus.d_evict) begin
          state_n   = ARB_WB;
          m_addr_n  = bus.d_evict_addr;
          m_wdata_n = bus.d_wr_line;
          m_we_n    = 1'b1;
          t_load    = 1'b1;
        end else if (bus.d_req) begin
          state_n  = ARB_DRD;
          m_addr_n = bus.d_addr;
          m_re_n   = 1'b1;
          t_load   = 1'b1;
        end else if (bus.i_req) begin
          state_n  = ARB_IRD;
          m_addr_n = bus.i_addr;
          m_re_n   = 1'b1;
          t_load   = 1'b1;
        end
      end
      ARB_WB: begin
        if (t_zero) begin
          state_n  = ARB_DRD;
          m_addr_n = bus.d_addr;
          m_re_n   = 1'b1;
          t_load   = 1'b1;
        end else begin
          m_we_n = 1'b1;
          t_dec  = 1'b1;
        end
      end
      ARB_DRD: begin
        if (t_zero) begin
          state_n  = ARB_DRESP;
          d_line_n = bus.m_rdata;
          d_done_n = 1'b1;
        end else begin
          m_re_n = 1'b1;
          t_dec  = 1'b1;
        end
      end
      ARB_IRD: begin
        if (t_zero) begin
          state_n  = ARB_IRESP;
          i_line_n = bus.m_rdata;
          i_done_n = 1'b1;
        end else begin
          m_re_n = 1'b1;
          t_dec  = 1'b1;
        end
      end
      ARB_DRESP: state_n = ARB_IDLE;
      ARB_IRESP: state_n = ARB_IDLE;
      default:   state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.m_re    <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.i_line  <= '0;
      bus.d_line  <= '0;
      bus.i_done  <= 1'b0;
      bus.d_done  <= 1'b0;
    end else begin
      state       <= state_n;
      bus.m_addr  <= m_addr_n;
      bus.m_wdata <= m_wdata_n;
      bus.m_re    <= m_re_n;
      bus.m_we    <= m_we_n;
      bus.i_line  <= i_line_n;
      bus.d_line  <= d_line_n;
      bus.i_done  <= i_done_n;
      bus.d_done  <= d_done_n;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_ifill_q, perf_dfill_q, perf_wb_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ifill_q <= '0;
      perf_dfill_q <= '0;
      perf_wb_q    <= '0;
    end else begin
      if ((state == ARB_IRD) && t_zero && (perf_ifill_q != 16'hFFFF))
        perf_ifill_q <= perf_ifill_q + 16'd1;
      if ((state == ARB_DRD) && t_zero && (perf_dfill_q != 16'hFFFF))
        perf_dfill_q <= perf_dfill_q + 16'd1;
      if ((state == ARB_WB) && t_zero && (perf_wb_q != 16'hFFFF))
        perf_wb_q <= perf_wb_q + 16'd1;
    end
  end

  assign perf_ifill = perf_ifill_q;
  assign perf_dfill = perf_dfill_q;
  assign perf_wb    = perf_wb_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with directed fills, priority and reset abort
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MEM_LAT = 4;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [63:0] wdata;
    int          start;
  } mexp_t;

  typedef struct packed {
    logic [63:0] line;
    int          cyc;
  } dexp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  mexp_t mq[$];
  dexp_t iq[$];
  dexp_t dq[$];

  logic [63:0] mem [0:16383];

  mem_arbiter_if bus ();

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_ifill, perf_dfill, perf_wb;
`endif

  mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_ifill(perf_ifill),
    .perf_dfill(perf_dfill),
    .perf_wb   (perf_wb)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.m_rdata = mem[bus.m_addr];
  always @(posedge clk) if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Done monitor: every done pulse must match the oldest expectation for its port.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.i_done) begin
        if (iq.size() == 0) check("i_done_unexpected", 64'd1, 64'd0);
        else begin
          dexp_t e;
          e = iq.pop_front();
          check("i_line", bus.i_line, e.line);
          check("i_done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (bus.d_done) begin
        if (dq.size() == 0) check("d_done_unexpected", 64'd1, 64'd0);
        else begin
          dexp_t e;
          e = dq.pop_front();
          check("d_line", bus.d_line, e.line);
          check("d_done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Memory-port monitor: each strobe run must match an expected access and last MEM_LAT cycles.
  logic [1:0] prev_s = 2'b00;
  int         run = 0;
  logic       have = 1'b0;
  mexp_t      cur_e;

  always @(negedge clk) begin
    logic [1:0] cur;
    if (!rst_n) begin
      prev_s = 2'b00;
      run    = 0;
      have   = 1'b0;
    end else begin
      cur = {bus.m_we, bus.m_re};
      if (cur == 2'b11) check("strobes_both", 64'd1, 64'd0);
      if ((cur != prev_s) && (prev_s != 2'b00)) check("strobe_len", 64'(run), 64'(MEM_LAT));
      if (cur != 2'b00) begin
        if (cur != prev_s) begin
          run = 0;
          if (mq.size() == 0) begin
            check("mem_access_unexpected", 64'd1, 64'd0);
            have = 1'b0;
          end else begin
            cur_e = mq.pop_front();
            have  = 1'b1;
            check("mem_start_cycle", 64'(cyc), 64'(cur_e.start));
            check("mem_we", 64'(bus.m_we), 64'(cur_e.we));
          end
        end
        run++;
        if (have) begin
          check("m_addr", 64'(bus.m_addr), 64'(cur_e.addr));
          if (cur_e.we) check("m_wdata", bus.m_wdata, cur_e.wdata);
        end
      end
      prev_s = cur;
    end
  end

  task automatic wait_i();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.i_done && n < 100);
    if (!bus.i_done) check("i_done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.i_req = 1'b0;
  endtask

  task automatic wait_d();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.d_done && n < 100);
    if (!bus.d_done) check("d_done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.d_req   = 1'b0;
    bus.d_evict = 1'b0;
  endtask

  task automatic do_i(input logic [13:0] a, input logic [63:0] line);
    int c;
    @(posedge clk); #1;
    c = cyc;
    mq.push_back('{1'b0, a, 64'd0, c + 1});
    iq.push_back('{line, c + MEM_LAT + 1});
    bus.i_addr = a;
    bus.i_req  = 1'b1;
    wait_i();
  endtask

  task automatic do_d(input logic [13:0] a, input logic ev, input logic [13:0] ea,
                      input logic [63:0] wl, input logic [63:0] line);
    int c;
    @(posedge clk); #1;
    c = cyc;
    if (ev) begin
      mq.push_back('{1'b1, ea, wl, c + 1});
      mq.push_back('{1'b0, a, 64'd0, c + MEM_LAT + 1});
      dq.push_back('{line, c + 2 * MEM_LAT + 1});
    end else begin
      mq.push_back('{1'b0, a, 64'd0, c + 1});
      dq.push_back('{line, c + MEM_LAT + 1});
    end
    bus.d_addr       = a;
    bus.d_evict      = ev;
    bus.d_evict_addr = ea;
    bus.d_wr_line    = wl;
    bus.d_req        = 1'b1;
    wait_d();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int k = 0; k < 16384; k++) mem[k] = 64'd0;
    mem[14'h0010] = 64'h1111_2222_3333_4444;
    mem[14'h0123] = 64'h0123_4567_89AB_CDEF;
    mem[14'h0300] = 64'h3333_0300_AAAA_5555;
    mem[14'h0040] = 64'h4040_4040_0000_0040;
    mem[14'h0050] = 64'h5050_5050_0000_0050;
    mem[14'h0060] = 64'h6060_6060_0000_0060;

    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_addr = '0; bus.d_evict = 1'b0;
    bus.d_evict_addr = '0; bus.d_wr_line = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_state", 64'(dut.state), 64'(ARB_IDLE));
    check("rst_m_re", 64'(bus.m_re), 64'd0);
    check("rst_m_we", 64'(bus.m_we), 64'd0);
    check("rst_m_addr", 64'(bus.m_addr), 64'd0);
    check("rst_m_wdata", bus.m_wdata, 64'd0);
    check("rst_i_line", bus.i_line, 64'd0);
    check("rst_d_line", bus.d_line, 64'd0);
    check("rst_dones", 64'({bus.i_done, bus.d_done}), 64'd0);

    do_i(14'h0010, 64'h1111_2222_3333_4444);
    do_d(14'h0123, 1'b0, 14'h0000, 64'd0, 64'h0123_4567_89AB_CDEF);
    do_d(14'h0300, 1'b1, 14'h0200, 64'hDEAD_BEEF_CAFE_F00D, 64'h3333_0300_AAAA_5555);
    check("wb_mem", mem[14'h0200], 64'hDEAD_BEEF_CAFE_F00D);
    check("i_line_hold", bus.i_line, 64'h1111_2222_3333_4444);

    // Simultaneous I and D requests: D wins, I is served after D's response cycle.
    @(posedge clk); #1;
    c = cyc;
    mq.push_back('{1'b0, 14'h0050, 64'd0, c + 1});
    mq.push_back('{1'b0, 14'h0040, 64'd0, c + 7});
    dq.push_back('{64'h5050_5050_0000_0050, c + 5});
    iq.push_back('{64'h4040_4040_0000_0040, c + 11});
    bus.i_addr = 14'h0040; bus.i_req = 1'b1;
    bus.d_addr = 14'h0050; bus.d_evict = 1'b0; bus.d_req = 1'b1;
    fork
      wait_d();
      wait_i();
    join
    check("d_line_hold", bus.d_line, 64'h5050_5050_0000_0050);

    // Reset asserted in cycle 2 of an I fill.
    @(posedge clk); #1;
    c = cyc;
    mq.push_back('{1'b0, 14'h0060, 64'd0, c + 1});
    bus.i_addr = 14'h0060; bus.i_req = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0; bus.i_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_cycle", 64'(cyc), 64'(c + 3));
    check("abort_m_re", 64'(bus.m_re), 64'd0);
    check("abort_state", 64'(dut.state), 64'(ARB_IDLE));
    check("abort_i_line", bus.i_line, 64'd0);
    repeat (10) @(posedge clk);
    #1;

    do_i(14'h0060, 64'h6060_6060_0000_0060);

`ifdef MEM_ARB_PERF_EN
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    do_i(14'h0010, 64'h1111_2222_3333_4444);
    do_i(14'h0040, 64'h4040_4040_0000_0040);
    do_d(14'h0300, 1'b1, 14'h0210, 64'h0BAD_F00D_0000_0210, 64'h3333_0300_AAAA_5555);
    do_d(14'h0123, 1'b0, 14'h0000, 64'd0, 64'h0123_4567_89AB_CDEF);
    check("perf_ifill", 64'(perf_ifill), 64'd2);
    check("perf_dfill", 64'(perf_dfill), 64'd2);
    check("perf_wb", 64'(perf_wb), 64'd1);
    @(negedge clk);
    dut.perf_wb_q = 16'hFFFF;
    do_d(14'h0300, 1'b1, 14'h0220, 64'h0BAD_F00D_0000_0220, 64'h3333_0300_AAAA_5555);
    check("perf_wb_sat", 64'(perf_wb), 64'hFFFF);
    check("perf_dfill_after", 64'(perf_dfill), 64'd3);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("mq_drained", 64'(mq.size()), 64'd0);
    check("iq_drained", 64'(iq.size()), 64'd0);
    check("dq_drained", 64'(dq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
